// File: rtl/n106_audio_lpf.sv
// n106_audio_lpf: one-pole IIR reconstruction low-pass for the Namco 106 channel sum.
// Latches each 11-bit channel-sum word, saturates it to 10 bits and scales it to 16 bits.
// On every ce tick it runs y += (x<<8 - y) >>> K through a multi-cycle FSM with a serial shifter.
// Ports:
//   clk          system clock
//   reset        synchronous active-high reset
//   ce           CPU M2 tick; each tick requests one filter update
//   enable       audio enable; when low the filter input is forced to 0
//   sample_valid strobe qualifying sample_in
//   sample_in    N106 channel sum (0..0x708)
//   audio_out    filtered 16-bit unsigned PCM, held between updates
//   audio_valid  one-cycle strobe when audio_out is updated
//   overrun      sticky flag: a ce tick was dropped
module n106_audio_lpf #(
    parameter int unsigned K = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        enable,
    input  logic        sample_valid,
    input  logic [10:0] sample_in,
    output logic [15:0] audio_out,
    output logic        audio_valid,
    output logic        overrun
);

    localparam int unsigned X_W  = 16;
    localparam int unsigned Y_W  = 24;
    localparam int unsigned WK_W = 25;
    localparam int unsigned SH_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_ACC   = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

    state_t            state_q,       state_d;
    logic              pending_q,     pending_d;
    logic              overrun_q,     overrun_d;
    logic [X_W-1:0]    x_hold_q,      x_hold_d;
    logic [Y_W-1:0]    y_q,           y_d;
    logic [WK_W-1:0]   work_q,        work_d;
    logic [SH_W-1:0]   sh_cnt_q,      sh_cnt_d;
    logic [15:0]       audio_out_q,   audio_out_d;
    logic              audio_valid_q, audio_valid_d;

    logic [9:0]        sat;
    logic [X_W-1:0]    x_eff;
    logic              busy;

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            pending_q     <= 1'b0;
            overrun_q     <= 1'b0;
            x_hold_q      <= '0;
            y_q           <= '0;
            work_q        <= '0;
            sh_cnt_q      <= '0;
            audio_out_q   <= '0;
            audio_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            overrun_q     <= overrun_d;
            x_hold_q      <= x_hold_d;
            y_q           <= y_d;
            work_q        <= work_d;
            sh_cnt_q      <= sh_cnt_d;
            audio_out_q   <= audio_out_d;
            audio_valid_q <= audio_valid_d;
        end
    end

    // Input capture, next-state and datapath sequencing
    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        overrun_d     = overrun_q;
        x_hold_d      = x_hold_q;
        y_d           = y_q;
        work_d        = work_q;
        sh_cnt_d      = sh_cnt_q;
        audio_out_d   = audio_out_q;
        audio_valid_d = 1'b0;

        sat   = (sample_in > 11'h3FF) ? 10'h3FF : sample_in[9:0];
        x_eff = enable ? x_hold_q : '0;
        busy  = (state_q == ST_LOAD) || (state_q == ST_SHIFT) || (state_q == ST_ACC);

        if (sample_valid && enable) begin
            x_hold_d = {sat, 6'b0};
        end

        // A tick arriving mid-update is queued once; a second one is lost.
        if (busy && ce) begin
            if (pending_q) begin
                overrun_d = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (ce || pending_q) begin
                    state_d   = ST_LOAD;
                    pending_d = pending_q && ce;
                end
            end
            ST_LOAD: begin
                work_d   = {1'b0, x_eff, 8'b0} - {1'b0, y_q};
                sh_cnt_d = SH_W'(K);
                state_d  = ST_SHIFT;
            end
            ST_SHIFT: begin
                // Arithmetic shift floors, so small negative deltas still reach zero.
                work_d   = {work_q[WK_W-1], work_q[WK_W-1:1]};
                sh_cnt_d = sh_cnt_q - SH_W'(1);
                if (sh_cnt_q == SH_W'(1)) begin
                    state_d = ST_ACC;
                end
            end
            ST_ACC: begin
                // Two's-complement wrap in 24 bits realises y + d.
                y_d           = y_q + work_q[Y_W-1:0];
                audio_out_d   = y_d[23:8];
                audio_valid_d = 1'b1;
                state_d       = ST_OUT;
            end
            ST_OUT: begin
                // A queued tick (or one arriving now) starts straight away, keeping back-to-back updates K+3 apart.
                if (ce || pending_q) begin
                    state_d   = ST_LOAD;
                    pending_d = pending_q && ce;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign audio_out   = audio_out_q;
    assign audio_valid = audio_valid_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_n106_audio_lpf.sv
module tb_n106_audio_lpf;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        enable;
    logic        sample_valid;
    logic [10:0] sample_in;
    logic [15:0] audio_out;
    logic        audio_valid;
    logic        overrun;

    int checks   = 0;
    int failures = 0;

    n106_audio_lpf #(.K(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .ce           (ce),
        .enable       (enable),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .audio_out    (audio_out),
        .audio_valid  (audio_valid),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] sin;
        logic        en;
        logic [15:0] xh;
        logic [15:0] o1;
        logic [15:0] o2;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic do_sample(input logic [10:0] v);
        sample_in    = v;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
    endtask

    // One ce tick, wait for audio_valid, report latency and whether the strobe dropped next cycle.
    task automatic do_tick(output logic [15:0] out, output int lat, output logic v_after);
        int n;
        ce = 1'b1;
        step();
        ce = 1'b0;
        lat = 1;
        while (audio_valid !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        out = audio_out;
        step();
        v_after = audio_valid;
        n = lat + 1;
        while (n < 12) begin
            step();
            n++;
        end
    endtask

    function automatic logic [23:0] model_step(input logic [23:0] y, input logic [15:0] x);
        logic signed [24:0] d;
        d = $signed({1'b0, x, 8'b0}) - $signed({1'b0, y});
        d = d >>> 4;
        return y + d[23:0];
    endfunction

    initial begin
        logic [15:0] o;
        logic [15:0] prev;
        logic        va;
        logic        seen;
        logic [23:0] ym;
        int          lat;
        int          vcnt;
        int          vc[2];
        logic [15:0] vo[2];
        int          iter;

        reset = 1'b1; ce = 1'b0; enable = 1'b1; sample_valid = 1'b0; sample_in = '0;

        vecs[0] = '{11'h3FF, 1'b1, 16'hFFC0, 16'h0FFC, 16'h1EF8};
        vecs[1] = '{11'h708, 1'b1, 16'hFFC0, 16'h0FFC, 16'h1EF8};
        vecs[2] = '{11'h400, 1'b1, 16'hFFC0, 16'h0FFC, 16'h1EF8};
        vecs[3] = '{11'h000, 1'b1, 16'h0000, 16'h0000, 16'h0000};
        vecs[4] = '{11'h001, 1'b1, 16'h0040, 16'h0004, 16'h0007};
        vecs[5] = '{11'h200, 1'b1, 16'h8000, 16'h0800, 16'h0F80};
        vecs[6] = '{11'h155, 1'b1, 16'h5540, 16'h0554, 16'h0A52};
        vecs[7] = '{11'h3FF, 1'b0, 16'h0000, 16'h0000, 16'h0000};

        do_reset();
        chk("reset_audio_out", 32'(audio_out), 32'h0);
        chk("reset_audio_valid", 32'(audio_valid), 32'h0);
        chk("reset_overrun", 32'(overrun), 32'h0);
        chk("reset_x_hold", 32'(dut.x_hold_q), 32'h0);

        // Step / saturation / enable table
        for (int i = 0; i < 8; i++) begin
            do_reset();
            enable = vecs[i].en;
            do_sample(vecs[i].sin);
            chk($sformatf("v%0d_x_hold", i), 32'(dut.x_hold_q), 32'(vecs[i].xh));
            do_tick(o, lat, va);
            chk($sformatf("v%0d_lat1", i), 32'(lat), 32'd7);
            chk($sformatf("v%0d_out1", i), 32'(o), 32'(vecs[i].o1));
            chk($sformatf("v%0d_pulse1", i), 32'(va), 32'h0);
            do_tick(o, lat, va);
            chk($sformatf("v%0d_lat2", i), 32'(lat), 32'd7);
            chk($sformatf("v%0d_out2", i), 32'(o), 32'(vecs[i].o2));
            enable = 1'b1;
        end

        // sample_valid together with ce: LOAD sees the new value
        do_reset();
        sample_in = 11'h200; sample_valid = 1'b1;
        do_tick(o, lat, va);
        sample_valid = 1'b0;
        chk("same_cycle_out", 32'(o), 32'h0800);

        // sample_valid mid-update only affects the next update
        do_reset();
        do_sample(11'h3FF);
        ce = 1'b1; step(); ce = 1'b0; step();
        do_sample(11'h000);
        seen = 1'b0; iter = 0;
        while (!seen && iter < 20) begin
            if (audio_valid === 1'b1) seen = 1'b1; else begin step(); iter++; end
        end
        chk("mid_sample_out1", 32'(audio_out), 32'h0FFC);
        repeat (6) step();
        do_tick(o, lat, va);
        chk("mid_sample_out2", 32'(o), 32'h0EFC);

        // Two ce one cycle apart: queued, no overrun
        do_reset();
        do_sample(11'h3FF);
        ce = 1'b1; step(); step(); ce = 1'b0;
        vcnt = 0; vc[0] = 0; vc[1] = 0; vo[0] = '0; vo[1] = '0;
        for (int c = 2; c <= 30; c++) begin
            if (audio_valid === 1'b1) begin
                if (vcnt < 2) begin vc[vcnt] = c; vo[vcnt] = audio_out; end
                vcnt++;
            end
            step();
        end
        chk("dbl_count", 32'(vcnt), 32'd2);
        chk("dbl_cyc1", 32'(vc[0]), 32'd7);
        chk("dbl_cyc2", 32'(vc[1]), 32'd14);
        chk("dbl_out1", 32'(vo[0]), 32'h0FFC);
        chk("dbl_out2", 32'(vo[1]), 32'h1EF8);
        chk("dbl_overrun", 32'(overrun), 32'h0);

        // Three ce in three cycles: one dropped, overrun sticky
        do_reset();
        do_sample(11'h3FF);
        ce = 1'b1; step(); step(); step(); ce = 1'b0;
        vcnt = 0; vc[0] = 0; vc[1] = 0;
        for (int c = 3; c <= 30; c++) begin
            if (audio_valid === 1'b1) begin
                if (vcnt < 2) vc[vcnt] = c;
                vcnt++;
            end
            step();
        end
        chk("tri_count", 32'(vcnt), 32'd2);
        chk("tri_cyc1", 32'(vc[0]), 32'd7);
        chk("tri_cyc2", 32'(vc[1]), 32'd14);
        chk("tri_overrun", 32'(overrun), 32'h1);
        do_tick(o, lat, va);
        do_tick(o, lat, va);
        chk("tri_overrun_sticky", 32'(overrun), 32'h1);
        do_reset();
        chk("tri_overrun_cleared", 32'(overrun), 32'h0);

        // Reset during SHIFT aborts the update
        do_reset();
        do_sample(11'h3FF);
        ce = 1'b1; step(); ce = 1'b0; step(); step();
        reset = 1'b1; step(); reset = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 15; c++) begin
            if (audio_valid === 1'b1) seen = 1'b1;
            step();
        end
        chk("rst_mid_no_valid", 32'(seen), 32'h0);
        chk("rst_mid_out", 32'(audio_out), 32'h0);
        do_sample(11'h3FF);
        do_tick(o, lat, va);
        chk("rst_mid_next_lat", 32'(lat), 32'd7);
        chk("rst_mid_next_out", 32'(o), 32'h0FFC);

        // Long step response, then decay to zero with enable low
        do_reset();
        do_sample(11'h3FF);
        ym = '0;
        for (int t = 0; t < 400; t++) begin
            do_tick(o, lat, va);
            ym = model_step(ym, 16'hFFC0);
            chk($sformatf("rise_%0d", t), 32'(o), 32'(ym[23:8]));
        end
        chk("rise_final_range", 32'(o == 16'hFFBF || o == 16'hFFC0), 32'h1);
        enable = 1'b0;
        prev = o;
        iter = 0;
        while (ym != 24'h0 && iter < 1000) begin
            do_tick(o, lat, va);
            ym = model_step(ym, 16'h0000);
            chk($sformatf("decay_%0d", iter), 32'(o), 32'(ym[23:8]));
            chk($sformatf("decay_mono_%0d", iter), 32'(o <= prev), 32'h1);
            prev = o;
            iter++;
        end
        chk("decay_bounded", 32'(iter < 1000), 32'h1);
        chk("decay_out_zero", 32'(audio_out), 32'h0);
        chk("decay_y_zero", 32'(dut.y_q), 32'h0);
        enable = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/n106_audio_lpf.md
# n106_audio_lpf

Reconstruction filter that sits directly downstream of the Namco 106 wavetable sound generator and upstream of the expansion-audio mixer. It latches each new 11-bit channel-sum word, saturates and scales it to 16 bits, and runs a one-pole IIR low-pass on every CPU tick to suppress the channel-multiplex whine. The filter is sequenced as a small multi-cycle FSM with a serial shifter. Its output is a held 16-bit unsigned PCM word with a one-cycle valid strobe.

## Interface
- K, default 4: filter shift, 1..7; coefficient is 2^-K.
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- ce  in  1  CPU M2 tick; each tick requests one filter update.
- enable  in  1  mapper audio enabled; when low the filter input is forced to 0.
- sample_valid  in  1  one-cycle strobe: new value present on sample_in.
- sample_in  in  11  N106 channel sum, range 0..0x708.
- audio_out  out  16  filtered unsigned PCM, held between updates.
- audio_valid  out  1  one-cycle strobe when audio_out changes.
- overrun  out  1  sticky: a ce tick was dropped; cleared only by reset.

## Operation
- Input hold register x_hold[15:0]:
  - On sample_valid with enable=1: sat = (sample_in > 0x3FF) ? 0x3FF : sample_in[9:0]; x_hold = {sat, 6'b0}.
  - enable=0 forces the effective x to 0 and ignores sample_valid. The output decays rather than stepping, so there is no pop.
- State y[23:0] is unsigned, with 8 fractional bits. audio_out = y[23:16+…]; specifically audio_out = y[23:8].
- Update per tick:
  - d = {1'b0, x, 8'b0} - {1'b0, y}, 25-bit signed.
  - d is arithmetic-shifted right by K. The shift floors, so d = -1 stays -1 and y decays exactly to 0.
  - y = y + d_shifted, kept to 24 bits. No overflow is possible because y stays ≤ x<<8.
- FSM states:
  - IDLE: on ce or pending, go to LOAD and clear pending.
  - LOAD: compute d into the 25-bit working register; sh_cnt=K. Go to SHIFT.
  - SHIFT: one arithmetic shift per cycle; sh_cnt--. Go to ACC when sh_cnt reaches 1 after its shift, i.e. after exactly K shifts.
  - ACC: y += work. Go to OUT.
  - OUT: audio_out = y[23:8]; audio_valid=1. Go to IDLE.
- The x used is x_hold as sampled in LOAD. A sample_valid arriving mid-update affects the next update only.
- Busy handling, for ce while FSM is not IDLE:
  - If pending=0, set pending=1. It is serviced immediately after OUT→IDLE, so IDLE goes straight to LOAD.
  - If pending=1, the tick is dropped and overrun=1.
- ce in the same cycle as the IDLE→LOAD transition driven by pending: that ce sets pending again. It is not dropped.
- sample_valid and ce in the same cycle: x_hold updates that cycle. LOAD, one cycle later, uses the new value.

## Timing
- Reset values: y=0, x_hold=0, audio_out=0x0000, audio_valid=0, overrun=0, pending=0, state=IDLE.
- Latency: ce in cycle N gives audio_valid and new audio_out in cycle N+K+3 (IDLE→LOAD at N+1, K SHIFT cycles, ACC, OUT). For K=4 this is N+7.
- Update occupancy is K+3 cycles. Sustained ce spacing must be ≥ K+3 cycles for zero pending. The real M2 spacing (~12 clk) satisfies this for all K ≤ 7.
- audio_valid is high for exactly one cycle. audio_out only changes in that cycle.
- Reset asserted mid-update aborts the update. All state returns to reset values on the next edge, and no audio_valid is emitted.
- enable has no effect on the FSM. Only x is affected.

## Test plan
- Step, K=4:
  - Stimulus: reset; sample_valid with 0x3FF; then ce ticks every 12 cycles.
  - Expect x_hold = 0xFFC0.
  - Expect first audio_out = 0x0FFC, second = 0x1EF8.
  - Expect audio_valid exactly 7 cycles after each ce.
- Saturation: sample_in = 0x708 → x_hold = 0xFFC0. The same output sequence as the step test is produced.
- Decay:
  - Stimulus: after 400 ticks at 0x3FF, audio_out must be 0xFFBF or 0xFFC0. Then drop enable to 0.
  - Expect monotonically non-increasing outputs reaching exactly 0x0000, with y = 0.
- Busy/overrun:
  - ce twice 1 cycle apart → two audio_valid pulses 7 cycles apart, overrun=0.
  - Three ce within 3 cycles → only two updates, overrun=1 and sticky until reset.
- Reset mid-update: assert reset during SHIFT → no audio_valid, audio_out=0x0000. The next ce after release yields 0x0FFC from a 0x3FF input.
